core_link_rx: RTL

Receive endpoint of the 14-bit inter-core ack/data link used between RISC621 cores in multicore builds. The sender places a word on its data port and flips a toggle token in its ack port. This block captures the word into a small FIFO, returns the token on its own ack port, and exposes the FIFO to the local core as a show-ahead read port. It sits beside a core's In/Out port pair, so software no longer has to poll the handshake by hand.

---
 rtl/link_pkg.sv | 18 +
 rtl/core_link_rx_if.sv | 28 ++
 rtl/link_fifo.sv | 58 +++++
 rtl/core_link_rx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared types and constants for the RISC621 inter-core ack/data link.
// Used by core_link_rx and the future core_link_tx.
package link_pkg;

  // Link word width; matches the core peripheral port width.
  localparam int LINK_W  = 14;
  // Bit of the ack word that carries the toggle token.
  localparam int TOK_BIT = 0;

  typedef logic [LINK_W-1:0] link_word_t;

  // Receiver handshake states.
  typedef enum logic {
    WAIT  = 1'b0,
    STALL = 1'b1
  } rx_state_t;

endpackage

// File: rtl/core_link_rx_if.sv
// core_link_rx_if: link-side and local-core-side signals of the link receiver.
// The slave modport is the receiver; the master modport is the sender plus local core.
interface core_link_rx_if #(
  parameter int DEPTH  = 8,
  parameter int LINK_W = link_pkg::LINK_W
);

  logic [LINK_W-1:0]      link_ack_in;
  logic [LINK_W-1:0]      link_data_in;
  logic [LINK_W-1:0]      link_ack_out;
  logic                   rd_en;
  logic [LINK_W-1:0]      rd_data;
  logic                   rd_valid;
  logic [$clog2(DEPTH):0] fill;
  logic                   proto_err;
  logic                   clr_err;

  modport master (
    output link_ack_in, link_data_in, rd_en, clr_err,
    input  link_ack_out, rd_data, rd_valid, fill, proto_err
  );

  modport slave (
    input  link_ack_in, link_data_in, rd_en, clr_err,
    output link_ack_out, rd_data, rd_valid, fill, proto_err
  );

endinterface

// File: rtl/link_fifo.sv
// link_fifo: synchronous FIFO with show-ahead read.
// A push is accepted when full only if a pop happens on the same edge.
// head reads 0 while the FIFO is empty.
module link_fifo #(
  parameter int DEPTH  = 8,
  parameter int LINK_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [LINK_W-1:0]      push_data,
  input  logic                   pop,
  output logic [LINK_W-1:0]      head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [LINK_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (fill == FW'(DEPTH));
  assign empty   = (fill == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: storage has no reset; fill/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); fill tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/core_link_rx.sv
// core_link_rx: receive endpoint of the 14-bit toggle-token inter-core link.
// Captures sender words into link_fifo, returns the token on link_ack_out and
// flags protocol violations on a sticky proto_err.
// Optional build macro LINK_RX_SYNC_EN: adds a synchronizer flop in front of the
// input register for cores on separate clocks (one extra edge of latency).
module core_link_rx #(
  parameter int DEPTH  = 8,
  parameter int LINK_W = link_pkg::LINK_W
) (
  input  logic           Clock_pin,
  input  logic           Resetn_pin,
  core_link_rx_if.slave  bus
);

  import link_pkg::rx_state_t;
  import link_pkg::WAIT;
  import link_pkg::STALL;
  import link_pkg::TOK_BIT;

  logic              tok_s;
  logic [LINK_W-1:0] data_s;
  logic              ack_tok;
  logic              proto_err;
  logic [LINK_W-1:0] hold_reg;
  rx_state_t         state;

  logic              pending;
  logic              push;
  logic [LINK_W-1:0] push_data;
  logic              set_err;
  logic              pop_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LINK_W-1:0] head;

  // Only the token bit of the sender's ack word carries meaning.
  logic unused_ack_bits;
  assign unused_ack_bits = ^bus.link_ack_in[LINK_W-1:TOK_BIT+1];

`ifdef LINK_RX_SYNC_EN
  logic              tok_m;
  logic [LINK_W-1:0] data_m;

  // Two-flop synchronizer whose second flop doubles as the input register.
  // Data rides alongside the token; it is stable well before the token flips.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      tok_m  <= 1'b0;
      data_m <= '0;
      tok_s  <= 1'b0;
      data_s <= '0;
    end else begin
      tok_m  <= bus.link_ack_in[TOK_BIT];
      data_m <= bus.link_data_in;
      tok_s  <= tok_m;
      data_s <= data_m;
    end
  end
`else
  // Single input register stage for same-clock cores.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      tok_s  <= 1'b0;
      data_s <= '0;
    end else begin
      tok_s  <= bus.link_ack_in[TOK_BIT];
      data_s <= bus.link_data_in;
    end
  end
`endif

  assign pending = (tok_s != ack_tok);
  assign pop_ok  = bus.rd_en & ~fifo_empty;

  // Push decision and error detection for the current state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push      = 1'b0;
    push_data = data_s;
    set_err   = 1'b0;
    case (state)
      WAIT: push = pending & ~fifo_full;
      STALL: begin
        push_data = hold_reg;
        if (!pending) begin
          // Sender withdrew its token while we were holding it off.
          set_err = 1'b1;
        end else begin
          set_err = (data_s != hold_reg);
          // Space freed by a pop on this edge releases the held word immediately.
          push    = ~fifo_full | pop_ok;
        end
      end
      default: ;
    endcase
  end

  // Handshake FSM: token echo, hold register and sticky error (set beats clear).
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      state     <= WAIT;
      ack_tok   <= 1'b0;
      hold_reg  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (pending) begin
            if (push) begin
              ack_tok <= tok_s;
            end else begin
              hold_reg <= data_s;
              state    <= STALL;
            end
          end
        end
        STALL: begin
          if (!pending) begin
            state <= WAIT;
          end else if (push) begin
            ack_tok <= tok_s;
            state   <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase

      if (set_err) begin
        proto_err <= 1'b1;
      end else if (bus.clr_err) begin
        proto_err <= 1'b0;
      end
    end
  end

  link_fifo #(
    .DEPTH  (DEPTH),
    .LINK_W (LINK_W)
  ) u_fifo (
    .clk       (Clock_pin),
    .rst_n     (Resetn_pin),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.rd_en),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (bus.fill)
  );

  // Token echo back to the sender; all other ack bits read as zero.
  always_comb begin
    bus.link_ack_out          = '0;
    bus.link_ack_out[TOK_BIT] = ack_tok;
  end

  assign bus.rd_data   = head;
  assign bus.rd_valid  = ~fifo_empty;
  assign bus.proto_err = proto_err;

endmodule
